// File: rtl/sap_computer.sv
// SAP-1.5 style 8-bit computer: 16-byte unified RAM, A/B registers, ALU with
// carry/zero flags, output register and a five-step (T0-T4) control sequencer.

module sap_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] ram [0:15];

    // Synchronous write; contents survive reset so a preloaded program persists.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    assign rdata = ram[addr];

    task dump();
        for (int i = 0; i < 16; i++) begin
            $display("ram[%0d] = %02h", i, ram[i]);
        end
    endtask
endmodule

module sap_register (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] d,
    output logic [7:0] q
);
    logic [7:0] latched_data;

    // Loadable 8-bit register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latched_data <= 8'h00;
        end else if (load) begin
            latched_data <= d;
        end
    end

    assign q = latched_data;
endmodule

module sap_computer (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] out_val
);
    typedef enum logic [2:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] A_SEL_ALU = 2'd0;
    localparam logic [1:0] A_SEL_RAM = 2'd1;
    localparam logic [1:0] A_SEL_IMM = 2'd2;

    tstate_e    state_r, state_next_s;
    logic [3:0] pc_r, mar_r;
    logic [7:0] ir_r, out_r;
    logic       carry_r, zero_r;
    logic       halt;

    logic [3:0] opcode_s, operand_s;
    logic [7:0] a_s, b_s, a_d_s, ram_rdata_s, alu_b_s;
    logic [8:0] alu_sum_s;
    logic [1:0] a_sel_s;
    logic       mar_pc_s, mar_ir_s, ir_load_s, pc_inc_s, pc_jump_s;
    logic       a_load_s, b_load_s, ram_we_s, out_load_s, flags_load_s;
    logic       alu_sub_s, halt_set_s;

    assign opcode_s  = ir_r[7:4];
    assign operand_s = ir_r[3:0];
    assign out_val   = out_r;

    sap_ram u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (mar_r),
        .wdata (a_s),
        .rdata (ram_rdata_s)
    );

    sap_register u_register_A (
        .clk   (clk),
        .reset (reset),
        .load  (a_load_s),
        .d     (a_d_s),
        .q     (a_s)
    );

    sap_register u_register_B (
        .clk   (clk),
        .reset (reset),
        .load  (b_load_s),
        .d     (ram_rdata_s),
        .q     (b_s)
    );

    // Subtraction is A + ~B + 1, so carry out of 1 means no borrow.
    assign alu_b_s   = alu_sub_s ? ~b_s : b_s;
    assign alu_sum_s = {1'b0, a_s} + {1'b0, alu_b_s} + {8'h00, alu_sub_s};

    // A register input select.
    always_comb begin
        a_d_s = alu_sum_s[7:0];
        case (a_sel_s)
            A_SEL_RAM: a_d_s = ram_rdata_s;
            A_SEL_IMM: a_d_s = {4'h0, operand_s};
            default:   a_d_s = alu_sum_s[7:0];
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= T0;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sequencer next state; it parks where it is once a HLT commits.
    always_comb begin
        state_next_s = state_r;
        if (halt || halt_set_s) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                T0:      state_next_s = T1;
                T1:      state_next_s = T2;
                T2:      state_next_s = T3;
                T3:      state_next_s = T4;
                T4:      state_next_s = T0;
                default: state_next_s = T0;
            endcase
        end
    end

    // Microcode: control strobes per step and opcode, all quiet while halted.
    always_comb begin
        mar_pc_s     = 1'b0;
        mar_ir_s     = 1'b0;
        ir_load_s    = 1'b0;
        pc_inc_s     = 1'b0;
        pc_jump_s    = 1'b0;
        a_load_s     = 1'b0;
        a_sel_s      = A_SEL_ALU;
        b_load_s     = 1'b0;
        ram_we_s     = 1'b0;
        out_load_s   = 1'b0;
        flags_load_s = 1'b0;
        alu_sub_s    = 1'b0;
        halt_set_s   = 1'b0;
        if (halt) begin
            halt_set_s = 1'b0;
        end else begin
            case (state_r)
                T0: mar_pc_s = 1'b1;
                T1: begin
                    ir_load_s = 1'b1;
                    pc_inc_s  = 1'b1;
                end
                T2: begin
                    case (opcode_s)
                        OP_LDA, OP_LDB, OP_STA: mar_ir_s = 1'b1;
                        OP_LDI: begin
                            a_load_s = 1'b1;
                            a_sel_s  = A_SEL_IMM;
                        end
                        OP_ADD: begin
                            a_load_s     = 1'b1;
                            flags_load_s = 1'b1;
                        end
                        OP_SUB: begin
                            a_load_s     = 1'b1;
                            flags_load_s = 1'b1;
                            alu_sub_s    = 1'b1;
                        end
                        OP_OUT:  out_load_s = 1'b1;
                        OP_JMP:  pc_jump_s  = 1'b1;
                        OP_JC:   pc_jump_s  = carry_r;
                        OP_JZ:   pc_jump_s  = zero_r;
                        OP_HLT:  halt_set_s = 1'b1;
                        default: halt_set_s = 1'b0;
                    endcase
                end
                T3: begin
                    case (opcode_s)
                        OP_LDA: begin
                            a_load_s = 1'b1;
                            a_sel_s  = A_SEL_RAM;
                        end
                        OP_LDB:  b_load_s = 1'b1;
                        OP_STA:  ram_we_s = 1'b1;
                        default: ram_we_s = 1'b0;
                    endcase
                end
                default: halt_set_s = 1'b0;
            endcase
        end
    end

    // Datapath registers: PC, MAR, IR, OUT, flags and halt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r    <= 4'h0;
            mar_r   <= 4'h0;
            ir_r    <= 8'h00;
            out_r   <= 8'h00;
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            halt    <= 1'b0;
        end else begin
            if (pc_jump_s) begin
                pc_r <= operand_s;
            end else if (pc_inc_s) begin
                pc_r <= pc_r + 4'd1;
            end
            if (mar_pc_s) begin
                mar_r <= pc_r;
            end else if (mar_ir_s) begin
                mar_r <= operand_s;
            end
            if (ir_load_s) begin
                ir_r <= ram_rdata_s;
            end
            if (out_load_s) begin
                out_r <= a_s;
            end
            if (flags_load_s) begin
                carry_r <= alu_sum_s[8];
                zero_r  <= (alu_sum_s[7:0] == 8'h00);
            end
            if (halt_set_s) begin
                halt <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sap_computer.sv
// Scoreboard bench for sap_computer: each program pushes its hand-computed
// final state; a monitor compares it against the machine when halt rises.

module tb_sap_computer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] out_val;

    sap_computer dut (
        .clk     (clk),
        .reset   (reset),
        .out_val (out_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [7:0]       a, b, o;
        logic             c, z;
        logic [3:0]       pc;
        logic [15:0][7:0] mem;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               vectors = 0;
    int               miscompares = 0;
    int               halts_seen = 0;
    logic             seen_ff = 1'b0;
    logic             prev_halt = 1'b0;
    logic [15:0][7:0] img;
    exp_t             e;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] o, input logic c, input logic z,
                                input logic [3:0] pc, input logic [15:0][7:0] mem);
        exp_t r;
        r.name = n; r.a = a; r.b = b; r.o = o; r.c = c; r.z = z; r.pc = pc; r.mem = mem;
        return r;
    endfunction

    // Monitor: pops the expected final state on every rising halt.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) seen_ff = 1'b0;
            else if (out_val == 8'hFF) seen_ff = 1'b1;
            if (dut.halt && !prev_halt) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_halt: got halt with empty scoreboard, expected none");
                end else begin
                    mon_e = sb_q.pop_front();
                    check({mon_e.name, " A"},     16'(dut.u_register_A.latched_data), 16'(mon_e.a));
                    check({mon_e.name, " B"},     16'(dut.u_register_B.latched_data), 16'(mon_e.b));
                    check({mon_e.name, " out"},   16'(out_val),     16'(mon_e.o));
                    check({mon_e.name, " C"},     16'(dut.carry_r), 16'(mon_e.c));
                    check({mon_e.name, " Z"},     16'(dut.zero_r),  16'(mon_e.z));
                    check({mon_e.name, " PC"},    16'(dut.pc_r),    16'(mon_e.pc));
                    check({mon_e.name, " no_FF"}, 16'(seen_ff),     16'd0);
                    for (int i = 0; i < 16; i++) begin
                        check($sformatf("%s ram[%0d]", mon_e.name, i),
                              16'(dut.u_ram.ram[i]), 16'(mon_e.mem[i]));
                    end
                end
                halts_seen++;
            end
            prev_halt = dut.halt;
        end
    end

    task automatic start_prog(input exp_t ex, input logic [15:0][7:0] im);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) dut.u_ram.ram[i] = im[i];
        sb_q.push_back(ex);
        reset = 1'b1;
    endtask

    task automatic wait_halt(input exp_t ex);
        int start;
        start = halts_seen;
        for (int k = 0; k < 60 && halts_seen == start; k++) @(negedge clk);
        if (halts_seen == start) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no halt in 60 cycles, expected halt", ex.name);
            sb_q.delete();
        end else begin
            repeat (10) @(negedge clk);
            check({ex.name, " frozen PC"}, 16'(dut.pc_r), 16'(ex.pc));
            check({ex.name, " frozen A"},  16'(dut.u_register_A.latched_data), 16'(ex.a));
            check({ex.name, " frozen halt"}, 16'(dut.halt), 16'd1);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst PC",   16'(dut.pc_r),    16'd0);
        check("rst IR",   16'(dut.ir_r),    16'd0);
        check("rst MAR",  16'(dut.mar_r),   16'd0);
        check("rst A",    16'(dut.u_register_A.latched_data), 16'd0);
        check("rst B",    16'(dut.u_register_B.latched_data), 16'd0);
        check("rst out",  16'(out_val),     16'd0);
        check("rst C",    16'(dut.carry_r), 16'd0);
        check("rst Z",    16'(dut.zero_r),  16'd0);
        check("rst halt", 16'(dut.halt),    16'd0);
        check("rst T0",   16'(dut.state_r), 16'd0);

        // LDB F; HLT
        img = '0; img[0] = 8'h2F; img[1] = 8'hF0; img[15] = 8'h11;
        e = mk("ldb", 8'h00, 8'h11, 8'h00, 1'b0, 1'b0, 4'd2, img);
        start_prog(e, img); wait_halt(e);

        // LDA E; LDB F; ADD; OUT; HLT -> 5 + 3
        img = '0; img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h30; img[3] = 8'hE0;
        img[4] = 8'hF0; img[14] = 8'h05; img[15] = 8'h03;
        e = mk("add", 8'h08, 8'h03, 8'h08, 1'b0, 1'b0, 4'd5, img);
        start_prog(e, img); wait_halt(e);

        // LDI 7; LDB F(=07); SUB; JZ 7; fall-through LDA E(=FF),OUT,HLT; taken OUT,HLT
        img = '0; img[0] = 8'h67; img[1] = 8'h2F; img[2] = 8'h40; img[3] = 8'h97;
        img[4] = 8'h1E; img[5] = 8'hE0; img[6] = 8'hF0; img[7] = 8'hE0; img[8] = 8'hF0;
        img[14] = 8'hFF; img[15] = 8'h07;
        e = mk("sub_jz", 8'h00, 8'h07, 8'h00, 1'b1, 1'b1, 4'd9, img);
        start_prog(e, img); wait_halt(e);

        // LDA E(=FF); LDB F(=01); ADD; JC 6; fall-through LDI C,OUT; HLT at 6
        img = '0; img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h30; img[3] = 8'h86;
        img[4] = 8'h6C; img[5] = 8'hE0; img[6] = 8'hF0; img[14] = 8'hFF; img[15] = 8'h01;
        e = mk("add_jc", 8'h00, 8'h01, 8'h00, 1'b1, 1'b1, 4'd7, img);
        start_prog(e, img); wait_halt(e);

        // LDI 9; STA D; HLT over a patterned RAM
        for (int i = 0; i < 16; i++) img[i] = {4'hA, 4'(i)};
        img[0] = 8'h69; img[1] = 8'h5D; img[2] = 8'hF0;
        e = mk("sta", 8'h09, 8'h00, 8'h00, 1'b0, 1'b0, 4'd3, img);
        e.mem[13] = 8'h09;
        start_prog(e, img); wait_halt(e);
        dut.u_ram.dump();

        // LDB F(=11); LDB E(=22); HLT, with reset pulsed during T3 of the second LDB
        img = '0; img[0] = 8'h2F; img[1] = 8'h2E; img[2] = 8'hF0;
        img[14] = 8'h22; img[15] = 8'h11;
        e = mk("midrst", 8'h00, 8'h22, 8'h00, 1'b0, 1'b0, 4'd3, img);
        start_prog(e, img);
        for (int k = 0; k < 40 && !(dut.pc_r == 4'd2 && dut.state_r == 3'd3); k++) @(negedge clk);
        check("midrst reached T3 PC", 16'(dut.pc_r), 16'd2);
        check("midrst pre B", 16'(dut.u_register_B.latched_data), 16'h11);
        #1 reset = 1'b0;
        #1;
        check("midrst async B",    16'(dut.u_register_B.latched_data), 16'd0);
        check("midrst async PC",   16'(dut.pc_r),    16'd0);
        check("midrst async T0",   16'(dut.state_r), 16'd0);
        check("midrst ram kept",   16'(dut.u_ram.ram[14]), 16'h22);
        @(negedge clk);
        reset = 1'b1;
        wait_halt(e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/sap_computer.md
# sap_computer

Top-level 8-bit SAP-1.5 style computer: a 16-byte unified RAM, program counter, instruction register, A and B registers, ALU with carry/zero flags, output register and a microcoded control sequencer. It executes a program preloaded into RAM from reset until a HLT instruction, then freezes. It is the whole design; benches drive only clock and reset and observe the output port plus hierarchical state.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- out_val  output  8  contents of the output register.
- Hierarchical names fixed for benches:
  - u_ram.ram: 16x8 array, preloadable.
  - u_ram.dump(): task printing all 16 locations.
  - u_register_B.latched_data: B register.
  - Also: u_register_A.latched_data, halt (1 = halted).

## Operation
- Instruction byte: opcode = bits[7:4], operand nibble n = bits[3:0]. Addresses are 4-bit.
- Opcodes:
  - 0 NOP.
  - 1 LDA: A <= RAM[n].
  - 2 LDB: B <= RAM[n].
  - 3 ADD: A <= A+B, flags updated.
  - 4 SUB: A <= A-B, flags updated.
  - 5 STA: RAM[n] <= A.
  - 6 LDI: A <= {4'h0,n}.
  - 7 JMP: PC <= n.
  - 8 JC: PC <= n if C=1.
  - 9 JZ: PC <= n if Z=1.
  - E OUT: OUT <= A.
  - F HLT: halt.
  - A-D: execute as NOP.
- ALU and flags:
  - ADD: 9-bit sum, C = bit 8, A = low 8 bits.
  - SUB: computed as A + ~B + 1; C = carry out (1 means no borrow).
  - Z = (8-bit result == 0).
  - Flags change only on ADD/SUB.
- PC is 4 bits and wraps from F to 0.
- out_val always reflects the OUT register.

## Timing
- Reset asserted (low), at any time including mid-instruction:
  - PC, IR, A, B, OUT, MAR, flags <= 0.
  - Sequencer <= T0; halt <= 0.
  - RAM contents preserved.
- After reset deasserts, fetch starts on the next rising edge.
- Each instruction takes exactly 5 clocks, T0-T4:
  - T0: MAR <= PC.
  - T1: IR <= RAM[MAR]; PC <= PC+1.
  - T2: MAR <= n for LDA/LDB/STA. Register/flag-only ops (LDI, ADD, SUB, OUT, jumps) commit in T2.
  - T3: LDA/LDB load from RAM[MAR]; STA writes RAM[MAR].
  - T4: idle, then return to T0.
- RAM: synchronous write, combinational read.
- HLT: at T2, halt <= 1 and the sequencer stops. While halted, no register, PC or RAM changes occur. Only reset clears halt.
- A value loaded at T3 is visible to the next instruction's T2.

## Test plan
- LDB: RAM[0]=2F, RAM[1]=F0, RAM[F]=11; release reset.
  - Required: halt within 50 cycles; B=0x11; A=0; out_val=0.
- LDA/ADD/OUT: RAM = 1E,2F,30,E0,F0; RAM[E]=05, RAM[F]=03.
  - Required: out_val=0x08, C=0, Z=0 at halt.
- SUB to zero, then JZ: LDI 7, LDB with M=07, SUB, JZ to an OUT-then-HLT path.
  - Required: Z=1, C=1, jump taken, out_val=0x00. The fall-through path writes FF, so FF must not appear.
- ADD carry plus JC: A=FF, B=01, ADD.
  - Required: A=00, C=1, Z=1; JC taken.
- STA: LDI 9, STA D, HLT.
  - Required: RAM[D]=09 after halt; all other RAM unchanged.
- Reset mid-run: assert reset low during T3 of an LDB.
  - Required: B and PC are 0 immediately, without waiting for a clock edge.
  - After release, the program reruns from address 0 and reaches the same final state.
